// File: rtl/pbdebounce_pkg.sv
// Shared defaults and helpers for the push-button debouncer.
// The hold-counter width is sized so the counter can hold HOLD_TICKS itself.
package pbdebounce_pkg;

  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_HOLD_TICKS = 1000;

  function automatic int hold_cnt_width(input int hold_ticks);
    return $clog2(hold_ticks + 1);
  endfunction

endpackage

// File: rtl/pbdebounce_ch.sv
// One debounced button channel: synchroniser, sample shift register,
// hysteresis level, edge pulses and a saturating long-press counter.
module pbdebounce_ch
  import pbdebounce_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic button,
  output logic pbreg,
  output logic press,
  output logic rel_pulse,
  output logic long_press
);

  localparam int CW = hold_cnt_width(HOLD_TICKS);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);

  logic             sync_a;
  logic             s;
  logic [DEPTH-1:0] shift;
  logic [DEPTH-1:0] shift_next;
  logic [CW-1:0]    hold_cnt;

  assign shift_next = {shift[DEPTH-2:0], s};

  // The synchroniser runs every clk so s is always settled when a tick arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_a <= button;
      s      <= sync_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift     <= '0;
      pbreg     <= 1'b0;
      press     <= 1'b0;
      rel_pulse <= 1'b0;
    end else begin
      press     <= 1'b0;
      rel_pulse <= 1'b0;
      if (tick) begin
        shift <= shift_next;
        if (&shift_next && !pbreg) begin
          pbreg <= 1'b1;
          press <= 1'b1;
        end else if (~|shift_next && pbreg) begin
          pbreg     <= 1'b0;
          rel_pulse <= 1'b1;
        end
      end
    end
  end

  // Uses the registered level, so counting begins on the tick after the rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!pbreg) begin
        hold_cnt <= '0;
      end else if (tick && hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + CW'(1);
        if (hold_cnt == HOLD_LAST) begin
          long_press <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pbdebounce_multi.sv
// N independent debounced push-button channels sharing one sample tick.
module pbdebounce_multi
  import pbdebounce_pkg::*;
#(
  parameter int N          = 4,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int HOLD_TICKS = DEFAULT_HOLD_TICKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [N-1:0] button,
  output logic [N-1:0] pbreg,
  output logic [N-1:0] press,
  output logic [N-1:0] rel_pulse,
  output logic [N-1:0] long_press
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    pbdebounce_ch #(
      .DEPTH      (DEPTH),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .button     (button[i]),
      .pbreg      (pbreg[i]),
      .press      (press[i]),
      .rel_pulse  (rel_pulse[i]),
      .long_press (long_press[i])
    );
  end

endmodule
